// File: rtl/rom_header_detect_pkg.sv
// Shared constants, types and helpers for the streaming SNES ROM header detector.
// Candidate base/mode tables, FSM encodings and mask arithmetic live here.
package rom_header_pkg;

    localparam int MAX_CAND = 4;

    localparam logic [23:0] CAND_BASE [4] = '{
        24'h007FC0, 24'h00FFC0, 24'h40FFC0, 24'h0081C0
    };

    localparam logic [1:0] CAND_MODE [4] = '{2'd0, 2'd1, 2'd2, 2'd0};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_DECIDE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [4:0] OFF_MAP     = 5'h15;
    localparam logic [4:0] OFF_TYPE    = 5'h16;
    localparam logic [4:0] OFF_RSZ     = 5'h17;
    localparam logic [4:0] OFF_RAM     = 5'h18;
    localparam logic [4:0] OFF_CMPL_LO = 5'h1C;
    localparam logic [4:0] OFF_CMPL_HI = 5'h1D;
    localparam logic [4:0] OFF_CSUM_LO = 5'h1E;
    localparam logic [4:0] OFF_CSUM_HI = 5'h1F;

    localparam int SMC_HDR_LEN = 512;

    typedef struct packed {
        logic [7:0] map;
        logic [7:0] rtype;
        logic [3:0] rsz;
        logic [3:0] rram;
    } hdr_fields_t;

    // Smallest n with (1024 << n) >= nbytes, clamped to 15.
    function automatic logic [3:0] fit_size(input logic [31:0] nbytes);
        logic [3:0] r;
        r = 4'd15;
        for (int n = 15; n >= 0; n--) begin
            if ((32'd1024 << n) >= nbytes) r = 4'(n);
        end
        return r;
    endfunction

    function automatic logic [31:0] size_mask(input logic [3:0] e);
        return (32'd1024 << e) - 32'd1;
    endfunction

endpackage

// File: rtl/rom_header_detect_if.sv
// Loader-side stream and header result bundle for rom_header_detect.
// master = loader/testbench, slave = detector.
interface rom_hdr_if #(
    parameter int ADDR_W = 24
);
    logic              start;
    logic              smc_skip;
    logic [7:0]        din;
    logic              din_valid;
    logic              img_done;
    logic [7:0]        dout;
    logic              dout_valid;
    logic [ADDR_W-1:0] byte_cnt;
    logic              hdr_valid;
    logic [1:0]        hdr_idx;
    logic [3:0]        hdr_score;
    logic [7:0]        map_ctrl;
    logic [7:0]        rom_type;
    logic [3:0]        rom_size;
    logic [3:0]        ram_size;
    logic [ADDR_W-1:0] rom_mask;
    logic [ADDR_W-1:0] ram_mask;

    modport master (
        output start, smc_skip, din, din_valid, img_done,
        input  dout, dout_valid, byte_cnt, hdr_valid, hdr_idx,
        input  hdr_score, map_ctrl, rom_type, rom_size, ram_size,
        input  rom_mask, ram_mask
    );

    modport slave (
        input  start, smc_skip, din, din_valid, img_done,
        output dout, dout_valid, byte_cnt, hdr_valid, hdr_idx,
        output hdr_score, map_ctrl, rom_type, rom_size, ram_size,
        output rom_mask, ram_mask
    );
endinterface

// File: rtl/rom_header_detect_cand.sv
// One header candidate: base comparator, capture registers and score.
// Score is forced to zero until the whole 32-byte window has streamed past.
module hdr_candidate
    import rom_header_pkg::*;
#(
    parameter int          ADDR_W = 24,
    parameter logic [23:0] BASE   = 24'h007FC0,
    parameter logic [1:0]  MODE   = 2'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data,
    input  logic [ADDR_W-1:0] cnt,
    output logic [3:0]        score,
    output hdr_fields_t       fields
);

    localparam logic [ADDR_W:0] B    = (ADDR_W+1)'(BASE);
    localparam logic [ADDR_W:0] LAST = B + (ADDR_W+1)'(31);

    logic [ADDR_W:0] rel;
    logic            hit;
    logic [7:0]      map_b;
    logic [7:0]      type_b;
    logic [7:0]      rsz_b;
    logic [7:0]      ram_b;
    logic [7:0]      cmpl_lo;
    logic [7:0]      cmpl_hi;
    logic [7:0]      csum_lo;
    logic [7:0]      csum_hi;
    logic [15:0]     sum;
    logic            complete;
    logic            csum_ok;
    logic            mode_ok;
    logic            rsz_ok;
    logic            ram_ok;

    assign rel = {1'b0, addr} - B;
    assign hit = we && ({1'b0, addr} >= B) && (rel < (ADDR_W+1)'(32));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            map_b   <= '0;
            type_b  <= '0;
            rsz_b   <= '0;
            ram_b   <= '0;
            cmpl_lo <= '0;
            cmpl_hi <= '0;
            csum_lo <= '0;
            csum_hi <= '0;
        end else if (hit) begin
            case (rel[4:0])
                OFF_MAP:     map_b   <= data;
                OFF_TYPE:    type_b  <= data;
                OFF_RSZ:     rsz_b   <= data;
                OFF_RAM:     ram_b   <= data;
                OFF_CMPL_LO: cmpl_lo <= data;
                OFF_CMPL_HI: cmpl_hi <= data;
                OFF_CSUM_LO: csum_lo <= data;
                OFF_CSUM_HI: csum_hi <= data;
                default: ;
            endcase
        end
    end

    assign sum      = {csum_hi, csum_lo} + {cmpl_hi, cmpl_lo};
    assign complete = {1'b0, cnt} > LAST;
    assign csum_ok  = sum == 16'hFFFF;
    // 0x53 is a LoROM variant whose low bits do not encode mode 0.
    assign mode_ok  = (map_b[1:0] == MODE) ||
                      (MODE == 2'd0 && map_b == 8'h53);
    assign rsz_ok   = rsz_b >= 8'd7 && rsz_b <= 8'd14;
    assign ram_ok   = ram_b <= 8'd7;

    always_comb begin
        score = '0;
        if (csum_ok) score = score + 4'd4;
        if (mode_ok) score = score + 4'd2;
        if (rsz_ok)  score = score + 4'd1;
        if (ram_ok)  score = score + 4'd1;
        if (!complete) score = '0;
    end

    assign fields.map   = map_b;
    assign fields.rtype = type_b;
    assign fields.rsz   = rsz_b[3:0];
    assign fields.rram  = ram_b[3:0];

endmodule

// File: rtl/rom_header_detect.sv
// Streaming SNES ROM header detector: strips an optional SMC header, scores
// candidate headers and publishes mapper fields and ROM/RAM masks.
module rom_header_detect
    import rom_header_pkg::*;
#(
    parameter int          NUM_CAND    = 3,
    parameter int          ADDR_W      = 24,
    parameter int          MIN_SCORE   = 4,
    parameter int          MASK_FLOOR  = 12,
    parameter logic [23:0] BASE_TBL [4] = CAND_BASE
) (
    input logic       wclk,
    input logic       reset,
    rom_hdr_if.slave  bus
);

    logic [1:0]  state;
    logic        skip_en;
    logic [9:0]  skip_cnt;
    logic [1:0]  dec_idx;
    logic [1:0]  best_idx;
    logic [3:0]  best_score;

    logic        accept;
    logic        skipping;
    logic        emit;

    logic [3:0]  c_score [MAX_CAND];
    hdr_fields_t c_fld   [MAX_CAND];

    logic [3:0]  cur_score;
    logic [3:0]  nxt_score;
    logic [1:0]  nxt_idx;
    logic        take;
    logic        last;
    logic        fb;
    hdr_fields_t win;
    logic [3:0]  rsz_n;
    logic [3:0]  ram_n;
    logic [3:0]  rom_e;

    assign accept   = state == ST_SCAN && bus.din_valid && !bus.start;
    assign skipping = skip_en && skip_cnt < 10'(SMC_HDR_LEN);
    assign emit     = accept && !skipping;

    genvar i;
    for (i = 0; i < MAX_CAND; i++) begin : g_cand
        if (i < NUM_CAND) begin : g_on
            hdr_candidate #(
                .ADDR_W (ADDR_W),
                .BASE   (BASE_TBL[i]),
                .MODE   (CAND_MODE[i])
            ) u_cand (
                .clk    (wclk),
                .reset  (reset),
                .clr    (bus.start),
                .we     (emit),
                .addr   (bus.byte_cnt),
                .data   (bus.din),
                .cnt    (bus.byte_cnt),
                .score  (c_score[i]),
                .fields (c_fld[i])
            );
        end else begin : g_off
            assign c_score[i] = '0;
            assign c_fld[i]   = '0;
        end
    end

    // Sequential argmax; strict compare keeps ties on the lower index.
    assign cur_score = c_score[dec_idx];
    assign take      = dec_idx == 2'd0 || cur_score > best_score;
    assign nxt_idx   = take ? dec_idx : best_idx;
    assign nxt_score = take ? cur_score : best_score;
    assign last      = dec_idx == 2'(NUM_CAND - 1);
    assign win       = c_fld[nxt_idx];
    assign fb        = nxt_score < 4'(MIN_SCORE);

    assign rsz_n = fb ? fit_size(32'(bus.byte_cnt)) : win.rsz;
    assign ram_n = fb ? 4'd0 : win.rram;
    assign rom_e = rsz_n > 4'(MASK_FLOOR) ? rsz_n : 4'(MASK_FLOOR);

    always_ff @(posedge wclk) begin
        if (reset) begin
            state          <= ST_IDLE;
            skip_en        <= 1'b0;
            skip_cnt       <= '0;
            dec_idx        <= '0;
            best_idx       <= '0;
            best_score     <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.byte_cnt   <= '0;
            bus.hdr_valid  <= 1'b0;
            bus.hdr_idx    <= '0;
            bus.hdr_score  <= '0;
            bus.map_ctrl   <= '0;
            bus.rom_type   <= '0;
            bus.rom_size   <= '0;
            bus.ram_size   <= '0;
            bus.rom_mask   <= '1;
            bus.ram_mask   <= '0;
        end else if (bus.start) begin
            state          <= ST_SCAN;
            skip_en        <= bus.smc_skip;
            skip_cnt       <= '0;
            dec_idx        <= '0;
            bus.dout_valid <= 1'b0;
            bus.byte_cnt   <= '0;
            bus.hdr_valid  <= 1'b0;
        end else begin
            bus.dout_valid <= emit;
            if (emit) begin
                bus.dout <= bus.din;
                if (bus.byte_cnt != '1) begin
                    bus.byte_cnt <= bus.byte_cnt + 1'b1;
                end
            end
            if (accept && skipping) begin
                skip_cnt <= skip_cnt + 10'd1;
            end
            case (state)
                ST_SCAN: begin
                    if (bus.img_done) begin
                        state   <= ST_DECIDE;
                        dec_idx <= '0;
                    end
                end
                ST_DECIDE: begin
                    best_idx   <= nxt_idx;
                    best_score <= nxt_score;
                    dec_idx    <= dec_idx + 2'd1;
                    if (last) begin
                        state         <= ST_DONE;
                        bus.hdr_valid <= 1'b1;
                        bus.hdr_idx   <= fb ? 2'd0 : nxt_idx;
                        bus.hdr_score <= nxt_score;
                        bus.map_ctrl  <= fb ? 8'h20 : win.map;
                        bus.rom_type  <= fb ? 8'h00 : win.rtype;
                        bus.rom_size  <= rsz_n;
                        bus.ram_size  <= ram_n;
                        bus.rom_mask  <= ADDR_W'(size_mask(rom_e));
                        bus.ram_mask  <= ram_n == 4'd0 ? '0 :
                                         ADDR_W'(size_mask(ram_n));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
